// File: rtl/index_conditioner_if.sv
// Index conditioner bus: drive-side control in, conditioned index outputs out.
interface index_conditioner_if;
    logic        enable;
    logic        index_n_raw;
    logic        index_pulse;
    logic        index_level;
    logic        index_timeout;
    logic [15:0] index_count;
    logic [7:0]  glitch_count;

    modport master (
        output enable, index_n_raw,
        input  index_pulse, index_level, index_timeout, index_count, glitch_count
    );

    modport slave (
        input  enable, index_n_raw,
        output index_pulse, index_level, index_timeout, index_count, glitch_count
    );
endinterface

// File: rtl/index_conditioner.sv
// Floppy /INDEX conditioner: synchronizer, persistence filter, holdoff FSM,
// timeout flag and index/glitch statistics.
module index_conditioner #(
    parameter int unsigned FILTER_CYCLES  = 200,
    parameter int unsigned HOLDOFF_CYCLES = 2_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    index_conditioner_if.slave bus
);
    localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ARMED, ACTIVE, HOLDOFF} state_t;

    state_t        state_q, state_d;
    logic          sync1, sync_idx;
    logic [FW-1:0] filt_cnt;
    logic [HW-1:0] hold_cnt, hold_next;
    logic [TW-1:0] tmo_cnt;
    logic          level_q, pulse_q, timeout_q;
    logic [15:0]   index_count_q;
    logic [7:0]    glitch_count_q;

    logic          mismatch, accept, rise, fall, filt_glitch;
    logic          pulse_d, reject_d;
    logic [1:0]    glitch_inc;
    logic [8:0]    glitch_sum;

    // Filter events: a run of FILTER_CYCLES mismatches flips the level.
    always_comb begin
        mismatch    = (sync_idx != level_q);
        accept      = mismatch && (filt_cnt == FW'(FILTER_CYCLES - 1));
        rise        = accept && sync_idx;
        fall        = accept && !sync_idx;
        filt_glitch = !mismatch && (filt_cnt != '0);
        hold_next   = (hold_cnt != '0) ? hold_cnt - HW'(1) : '0;
    end

    // Next-state and strobe decode; a rise seen in HOLDOFF is a rejected event.
    always_comb begin
        state_d  = state_q;
        pulse_d  = 1'b0;
        reject_d = 1'b0;
        if (bus.enable) begin
            case (state_q)
                ARMED: begin
                    if (rise) begin
                        state_d = ACTIVE;
                        pulse_d = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (fall) state_d = (hold_next != '0) ? HOLDOFF : ARMED;
                end
                HOLDOFF: begin
                    if (rise) begin
                        state_d  = ACTIVE;
                        reject_d = 1'b1;
                    end else if (hold_next == '0) begin
                        state_d = ARMED;
                    end
                end
                default: state_d = ARMED;
            endcase
        end else begin
            state_d = ARMED;
        end
    end

    always_comb begin
        glitch_inc = {1'b0, filt_glitch} + {1'b0, reject_d};
        glitch_sum = {1'b0, glitch_count_q} + 9'(glitch_inc);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ARMED;
            sync1          <= 1'b0;
            sync_idx       <= 1'b0;
            filt_cnt       <= '0;
            hold_cnt       <= '0;
            tmo_cnt        <= '0;
            level_q        <= 1'b0;
            pulse_q        <= 1'b0;
            timeout_q      <= 1'b0;
            index_count_q  <= '0;
            glitch_count_q <= '0;
        end else begin
            state_q  <= state_d;
            sync1    <= ~bus.index_n_raw;
            sync_idx <= sync1;
            if (!bus.enable) begin
                filt_cnt  <= '0;
                hold_cnt  <= '0;
                tmo_cnt   <= '0;
                level_q   <= 1'b0;
                pulse_q   <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                if (accept) begin
                    level_q  <= sync_idx;
                    filt_cnt <= '0;
                end else if (mismatch) begin
                    filt_cnt <= filt_cnt + FW'(1);
                end else begin
                    filt_cnt <= '0;
                end

                pulse_q <= pulse_d;
                if (pulse_d) begin
                    index_count_q <= index_count_q + 16'd1;
                    hold_cnt      <= HW'(HOLDOFF_CYCLES);
                    tmo_cnt       <= '0;
                    timeout_q     <= 1'b0;
                end else begin
                    hold_cnt <= hold_next;
                    if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
                    end
                end

                glitch_count_q <= (glitch_sum > 9'd255) ? 8'd255 : glitch_sum[7:0];
            end
        end
    end

    assign bus.index_pulse   = pulse_q;
    assign bus.index_level   = level_q;
    assign bus.index_timeout = timeout_q;
    assign bus.index_count   = index_count_q;
    assign bus.glitch_count  = glitch_count_q;
endmodule

// File: tb/tb_index_conditioner.sv
// Randomized and directed bench for index_conditioner against an event-level model.
module tb_index_conditioner;
    localparam int unsigned F = 4;
    localparam int unsigned H = 100;
    localparam int unsigned T = 1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    index_conditioner_if bus ();

    index_conditioner #(
        .FILTER_CYCLES (F),
        .HOLDOFF_CYCLES(H),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: level flips after F consecutive disagreeing samples;
    // a rise is accepted only if more than H edges passed since the last accept.
    bit      m_s1, m_sync, m_level, m_pulse, m_timeout, m_rise;
    int      m_run, m_since, m_g, m_icount, m_gcount;
    longint  m_edge, m_last_acc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = 0; m_sync = 0; m_level = 0; m_pulse = 0; m_timeout = 0;
            m_run = 0; m_since = 0; m_icount = 0; m_gcount = 0;
            m_edge = 0; m_last_acc = -1;
        end else begin
            m_edge++;
            if (bus.enable) begin
                m_rise  = 0;
                m_g     = 0;
                m_pulse = 0;
                if (m_sync != m_level) begin
                    m_run++;
                    if (m_run == int'(F)) begin
                        m_level = m_sync;
                        m_run   = 0;
                        m_rise  = m_level;
                    end
                end else begin
                    if (m_run != 0) m_g++;
                    m_run = 0;
                end
                if (m_rise && (m_last_acc < 0 || m_edge - m_last_acc > longint'(H))) begin
                    m_pulse    = 1;
                    m_icount   = (m_icount + 1) % 65536;
                    m_last_acc = m_edge;
                    m_since    = 0;
                    m_timeout  = 0;
                end else begin
                    if (m_rise) m_g++;
                    if (m_since < int'(T)) m_since++;
                    if (m_since >= int'(T)) m_timeout = 1;
                end
                m_gcount = (m_gcount + m_g > 255) ? 255 : m_gcount + m_g;
            end else begin
                m_level = 0; m_run = 0; m_pulse = 0; m_timeout = 0;
                m_since = 0; m_last_acc = -1;
            end
            m_sync = m_s1;
            m_s1   = ~bus.index_n_raw;
        end
    end

    function automatic logic [26:0] dut_vec();
        return {bus.index_pulse, bus.index_level, bus.index_timeout, bus.index_count, bus.glitch_count};
    endfunction

    function automatic logic [26:0] model_vec();
        return {m_pulse, m_level, m_timeout, 16'(m_icount), 8'(m_gcount)};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.enable = 1'b0;
        bus.index_n_raw = 1'b1;
        reset_n = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (dut_vec() !== 27'd0) begin
            n_err++; $display("FAIL reset_state got %h exp 0", dut_vec());
        end
        reset_n = 1'b1;
        bus.enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL reset_idle cyc %0d got %h exp %h", k, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_clean_pulse();
        int first = -1;
        int pulses = 0;
        bus.index_n_raw = 1'b0;
        for (int k = 1; k <= 170; k++) begin
            if (k == 51) bus.index_n_raw = 1'b1;
            tick();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL clean_model cyc %0d got %h exp %h", k, dut_vec(), model_vec());
            end
            if (bus.index_pulse) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        n_vec++;
        if (first !== 6 || pulses !== 1) begin
            n_err++; $display("FAIL clean_latency got first=%0d n=%0d exp first=6 n=1", first, pulses);
        end
        n_vec++;
        if (bus.index_count !== 16'd1 || bus.glitch_count !== 8'd0) begin
            n_err++; $display("FAIL clean_counts got %0d/%0d exp 1/0", bus.index_count, bus.glitch_count);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        bit saw_level = 0;
        for (int k = 1; k <= 20; k++) begin
            bus.index_n_raw = (k <= 3) ? 1'b0 : 1'b1;
            tick();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL glitch_model cyc %0d got %h exp %h", k, dut_vec(), model_vec());
            end
            pulses += int'(bus.index_pulse);
            saw_level |= bus.index_level;
        end
        n_vec++;
        if (pulses !== 0 || saw_level !== 1'b0 || bus.glitch_count !== 8'd1) begin
            n_err++; $display("FAIL glitch_reject got p=%0d lvl=%0d g=%0d exp 0/0/1", pulses, saw_level, bus.glitch_count);
        end
    endtask

    task automatic test_holdoff();
        int edges[$];
        for (int t = 0; t < 320; t++) begin
            bus.index_n_raw = ((t < 20) || (t >= 60 && t < 80) || (t >= 200 && t < 220)) ? 1'b0 : 1'b1;
            tick();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL holdoff_model cyc %0d got %h exp %h", t, dut_vec(), model_vec());
            end
            if (bus.index_pulse) edges.push_back(t + 1);
        end
        n_vec++;
        if (edges.size() != 2) begin
            n_err++; $display("FAIL holdoff_pulses got %0d exp 2", edges.size());
        end else if (edges[0] != 6 || edges[1] != 206) begin
            n_err++; $display("FAIL holdoff_timing got %0d,%0d exp 6,206", edges[0], edges[1]);
        end
        n_vec++;
        if (bus.glitch_count !== 8'd2 || bus.index_count !== 16'd3) begin
            n_err++; $display("FAIL holdoff_counts got g=%0d i=%0d exp 2/3", bus.glitch_count, bus.index_count);
        end
    endtask

    task automatic test_timeout();
        int first = -1;
        bit seen = 0;
        bit prev;
        bus.index_n_raw = 1'b1;
        bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL timeout_model cyc %0d got %h exp %h", k, dut_vec(), model_vec());
            end
            if (bus.index_timeout && first < 0) first = k;
        end
        n_vec++;
        if (first !== 1000) begin
            n_err++; $display("FAIL timeout_assert got cyc %0d exp 1000", first);
        end
        bus.index_n_raw = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            prev = bus.index_timeout;
            tick();
            if (bus.index_pulse) begin
                seen = 1;
                n_vec++;
                if (bus.index_timeout !== 1'b0 || prev !== 1'b1) begin
                    n_err++; $display("FAIL timeout_clear got now=%0d before=%0d exp 0/1", bus.index_timeout, prev);
                end
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL timeout_pulse got none exp one");
        end
        bus.index_n_raw = 1'b1;
        for (int k = 0; k < 120; k++) begin
            tick();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL timeout_tail cyc %0d got %h exp %h", k, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_reset_holdoff();
        int first = -1;
        int pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            bus.index_n_raw = (k <= 20) ? 1'b0 : 1'b1;
            tick();
        end
        bus.index_n_raw = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (dut_vec() !== 27'd0) begin
            n_err++; $display("FAIL reset_async got %h exp 0", dut_vec());
        end
        repeat (3) tick();
        n_vec++;
        if (dut_vec() !== 27'd0) begin
            n_err++; $display("FAIL reset_hold got %h exp 0", dut_vec());
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL reset_release cyc %0d got %h exp %h", k, dut_vec(), model_vec());
            end
            if (bus.index_pulse) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        n_vec++;
        if (first !== 6 || pulses !== 1 || bus.index_count !== 16'd1) begin
            n_err++; $display("FAIL reset_rearm got first=%0d n=%0d i=%0d exp 6/1/1", first, pulses, bus.index_count);
        end
    endtask

    task automatic test_enable_drop();
        int first = -1;
        int pulses = 0;
        bus.enable = 1'b0;
        tick();
        n_vec++;
        if (bus.index_pulse !== 1'b0 || bus.index_level !== 1'b0 || bus.index_count !== 16'd1) begin
            n_err++; $display("FAIL enable_clear got p=%0d l=%0d i=%0d exp 0/0/1", bus.index_pulse, bus.index_level, bus.index_count);
        end
        bus.enable = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL enable_model cyc %0d got %h exp %h", k, dut_vec(), model_vec());
            end
            if (bus.index_pulse) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        n_vec++;
        if (first !== 4 || pulses !== 1 || bus.index_count !== 16'd2) begin
            n_err++; $display("FAIL enable_rearm got first=%0d n=%0d i=%0d exp 4/1/2", first, pulses, bus.index_count);
        end
    endtask

    task automatic test_glitch_saturation();
        int lo, hi;
        bus.index_n_raw = 1'b1;
        repeat (20) tick();
        for (int g = 0; g < 300; g++) begin
            lo = int'($urandom_range(1, 3));
            hi = int'($urandom_range(2, 6));
            for (int k = 0; k < lo + hi; k++) begin
                bus.index_n_raw = (k < lo) ? 1'b0 : 1'b1;
                tick();
                n_vec++;
                if (dut_vec() !== model_vec()) begin
                    n_err++; $display("FAIL sat_model glitch %0d got %h exp %h", g, dut_vec(), model_vec());
                end
            end
        end
        repeat (4) tick();
        n_vec++;
        if (bus.glitch_count !== 8'd255) begin
            n_err++; $display("FAIL glitch_saturate got %0d exp 255", bus.glitch_count);
        end
    endtask

    task automatic test_random();
        int run_left = 0;
        bit prev_pulse = 0;
        for (int k = 0; k < 3000; k++) begin
            if (run_left == 0) begin
                bus.index_n_raw = ~bus.index_n_raw;
                run_left = int'($urandom_range(1, 12));
            end
            run_left--;
            bus.enable = ($urandom_range(0, 63) != 0);
            tick();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL random_model cyc %0d got %h exp %h", k, dut_vec(), model_vec());
            end
            if (prev_pulse && bus.index_pulse) begin
                n_vec++;
                n_err++; $display("FAIL pulse_width cyc %0d got 2 high cycles exp 1", k);
            end
            prev_pulse = bus.index_pulse;
        end
        bus.enable = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.enable = 1'b0;
        bus.index_n_raw = 1'b1;
        test_reset();
        test_clean_pulse();
        test_glitch();
        test_holdoff();
        test_timeout();
        test_reset_holdoff();
        test_enable_drop();
        test_glitch_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
